// File: rtl/mul18_pkg.sv
// mul18_pkg: shared constants, column geometry helpers and FSM state type for the 18x18 feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mul18_pkg;

    localparam int W    = 18;
    localparam int NCOL = 2 * W - 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        SETTLE,
        DONE
    } feeder_state_t;

    // Number of partial-product bits that land in column k.
    function automatic int col_height(input int k);
        return ((k < (NCOL - 1 - k)) ? k : (NCOL - 1 - k)) + 1;
    endfunction

    // Row index of the first partial product in column k.
    function automatic int col_base(input int k);
        return (k > (W - 1)) ? (k - (W - 1)) : 0;
    endfunction

endpackage

// File: rtl/mul18_pp_column_mux.sv
// mul18_pp_column_mux: picks the partial-product bit of column K that belongs to sweep step cnt.
// Latency: purely combinational from the registered a/b/cnt of the parent.
// Backpressure: none; output is 0 whenever shifting is low.
// Ports: a, b (registered operands), cnt (sweep step 0..17), shifting (sweep active), src_bit (serial bit).
module mul18_pp_column_mux
    import mul18_pkg::*;
#(
    parameter int K = 0
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [4:0]   cnt,
    input  logic         shifting,
    output logic         src_bit
);

    localparam int          H    = col_height(K);
    localparam int          I0   = col_base(K);
    localparam logic [4:0]  LAST = 5'(W - 1);

    // entry[r] is the r-th bit of this column; rows beyond the column height read as 0.
    logic [W-1:0] entry;

    for (genvar r = 0; r < W; r++) begin : g_ent
        if (r < H) begin : g_on
            assign entry[r] = a[I0+r] & b[K-I0-r];
        end else begin : g_off
            assign entry[r] = 1'b0;
        end
    end

    // Highest entry goes out first so that entry r ends up at shift-register bit r.
    assign src_bit = shifting & entry[LAST - cnt];

endmodule

// File: rtl/mul18_pp_feeder.sv
// mul18_pp_feeder: serializes the 18x18 AND-array onto 35 column lines, then captures and checks the compressor sum.
// Latency: accept -> result_valid after 19+SETTLE_CYCLES cycles; one operation per 20+SETTLE_CYCLES cycles.
// Backpressure: in_ready only in IDLE; in_valid and a/b are ignored while a sweep is in flight.
// Ports: clk, rst_n (synchronous, active-low); in_valid/in_ready/a/b operand handshake;
//        src0_..src34_ serial column bits; dst0..dst35 compressor sum bits;
//        result_valid, result, expected, mismatch, err_count check outputs.
module mul18_pp_feeder #(
    parameter int W             = 18,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           src0_,  src1_,  src2_,  src3_,  src4_,  src5_,  src6_,
    output logic           src7_,  src8_,  src9_,  src10_, src11_, src12_, src13_,
    output logic           src14_, src15_, src16_, src17_, src18_, src19_, src20_,
    output logic           src21_, src22_, src23_, src24_, src25_, src26_, src27_,
    output logic           src28_, src29_, src30_, src31_, src32_, src33_, src34_,
    input  logic           dst0,  dst1,  dst2,  dst3,  dst4,  dst5,  dst6,  dst7,  dst8,
    input  logic           dst9,  dst10, dst11, dst12, dst13, dst14, dst15, dst16, dst17,
    input  logic           dst18, dst19, dst20, dst21, dst22, dst23, dst24, dst25, dst26,
    input  logic           dst27, dst28, dst29, dst30, dst31, dst32, dst33, dst34, dst35,
    output logic           result_valid,
    output logic [2*W-1:0] result,
    output logic [2*W-1:0] expected,
    output logic           mismatch,
    output logic [15:0]    err_count
);
    import mul18_pkg::*;

    localparam int                SW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0]     SLAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [4:0]        CLAST = 5'(W - 1);

    feeder_state_t    state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [SW-1:0]    scnt_q, scnt_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic [2*W-1:0]   expected_q, expected_d;
    logic [2*W-1:0]   result_q, result_d;
    logic             result_valid_q, result_valid_d;
    logic             mismatch_q, mismatch_d;
    logic [15:0]      err_count_q, err_count_d;

    logic [NCOL-1:0]  src_vec;
    logic [2*W-1:0]   dst_vec;
    logic             shifting;

    assign dst_vec = {dst35, dst34, dst33, dst32, dst31, dst30, dst29, dst28, dst27,
                      dst26, dst25, dst24, dst23, dst22, dst21, dst20, dst19, dst18,
                      dst17, dst16, dst15, dst14, dst13, dst12, dst11, dst10, dst9,
                      dst8,  dst7,  dst6,  dst5,  dst4,  dst3,  dst2,  dst1,  dst0};

    assign {src34_, src33_, src32_, src31_, src30_, src29_, src28_,
            src27_, src26_, src25_, src24_, src23_, src22_, src21_,
            src20_, src19_, src18_, src17_, src16_, src15_, src14_,
            src13_, src12_, src11_, src10_, src9_,  src8_,  src7_,
            src6_,  src5_,  src4_,  src3_,  src2_,  src1_,  src0_} = src_vec;

    // Gated with rst_n so the feeder never advertises readiness while held in reset.
    assign in_ready     = rst_n && (state_q == IDLE);
    assign shifting     = (state_q == SHIFT);
    assign result_valid = result_valid_q;
    assign result       = result_q;
    assign expected     = expected_q;
    assign mismatch     = mismatch_q;
    assign err_count    = err_count_q;

    for (genvar k = 0; k < NCOL; k++) begin : g_col
        mul18_pp_column_mux #(.K(k)) u_col (
            .a        (a_q),
            .b        (b_q),
            .cnt      (cnt_q),
            .shifting (shifting),
            .src_bit  (src_vec[k])
        );
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        scnt_d         = scnt_q;
        a_d            = a_q;
        b_d            = b_q;
        expected_d     = expected_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        mismatch_d     = 1'b0;
        err_count_d    = err_count_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    a_d        = a;
                    b_d        = b;
                    expected_d = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                    cnt_d      = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == CLAST) begin
                    scnt_d  = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                scnt_d = scnt_q + 1'b1;
                if (scnt_q == SLAST) begin
                    result_d       = dst_vec;
                    mismatch_d     = (dst_vec != expected_q);
                    result_valid_d = 1'b1;
                    state_d        = DONE;
                end
            end
            DONE: begin
                if (mismatch_q && (err_count_q != 16'hFFFF)) begin
                    err_count_d = err_count_q + 16'd1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            scnt_q         <= '0;
            a_q            <= '0;
            b_q            <= '0;
            expected_q     <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            mismatch_q     <= 1'b0;
            err_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            scnt_q         <= scnt_d;
            a_q            <= a_d;
            b_q            <= b_d;
            expected_q     <= expected_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            mismatch_q     <= mismatch_d;
            err_count_q    <= err_count_d;
        end
    end

endmodule

// File: tb/tb_mul18_pp_feeder.sv
// tb_mul18_pp_feeder: drives operand pairs into the feeder, emulates the column shift registers and compressor.
// Latency: n/a (bench).
// Backpressure: honours in_ready before releasing in_valid.
`define FEEDER_LINES(S, D) \
    .src0_(S[0]),   .src1_(S[1]),   .src2_(S[2]),   .src3_(S[3]),   .src4_(S[4]),   .src5_(S[5]),   .src6_(S[6]), \
    .src7_(S[7]),   .src8_(S[8]),   .src9_(S[9]),   .src10_(S[10]), .src11_(S[11]), .src12_(S[12]), .src13_(S[13]), \
    .src14_(S[14]), .src15_(S[15]), .src16_(S[16]), .src17_(S[17]), .src18_(S[18]), .src19_(S[19]), .src20_(S[20]), \
    .src21_(S[21]), .src22_(S[22]), .src23_(S[23]), .src24_(S[24]), .src25_(S[25]), .src26_(S[26]), .src27_(S[27]), \
    .src28_(S[28]), .src29_(S[29]), .src30_(S[30]), .src31_(S[31]), .src32_(S[32]), .src33_(S[33]), .src34_(S[34]), \
    .dst0(D[0]),   .dst1(D[1]),   .dst2(D[2]),   .dst3(D[3]),   .dst4(D[4]),   .dst5(D[5]),   .dst6(D[6]), \
    .dst7(D[7]),   .dst8(D[8]),   .dst9(D[9]),   .dst10(D[10]), .dst11(D[11]), .dst12(D[12]), .dst13(D[13]), \
    .dst14(D[14]), .dst15(D[15]), .dst16(D[16]), .dst17(D[17]), .dst18(D[18]), .dst19(D[19]), .dst20(D[20]), \
    .dst21(D[21]), .dst22(D[22]), .dst23(D[23]), .dst24(D[24]), .dst25(D[25]), .dst26(D[26]), .dst27(D[27]), \
    .dst28(D[28]), .dst29(D[29]), .dst30(D[30]), .dst31(D[31]), .dst32(D[32]), .dst33(D[33]), .dst34(D[34]), \
    .dst35(D[35])

module tb_mul18_pp_feeder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          chk_en = 1'b0;

    // Instance under full per-cycle checking (SETTLE_CYCLES = 1).
    logic        iv1 = 1'b0;
    logic        rdy1, rv1, mm1;
    logic [17:0] a1 = '0, b1 = '0;
    wire  [34:0] src1;
    logic [35:0] dst1 = '0;
    logic [35:0] res1, exp1;
    logic [15:0] err1;

    // Instance used for the longer settle timing (SETTLE_CYCLES = 3).
    logic        iv3 = 1'b0;
    logic        rdy3, rv3, mm3;
    logic [17:0] a3 = '0, b3 = '0;
    wire  [34:0] src3;
    logic [35:0] dst3 = '0;
    logic [35:0] res3, exp3;
    logic [15:0] err3;

    mul18_pp_feeder #(.W(18), .SETTLE_CYCLES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(rdy1), .a(a1), .b(b1),
        `FEEDER_LINES(src1, dst1),
        .result_valid(rv1), .result(res1), .expected(exp1), .mismatch(mm1), .err_count(err1)
    );

    mul18_pp_feeder #(.W(18), .SETTLE_CYCLES(3)) u3 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(rdy3), .a(a3), .b(b3),
        `FEEDER_LINES(src3, dst3),
        .result_valid(rv3), .result(res3), .expected(exp3), .mismatch(mm3), .err_count(err3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // ---------------- behavioural model of the S=1 instance ----------------
    int          ph = 0;                 // 0 idle, else cycles since accept (1..20)
    logic [17:0] m_a = '0, m_b = '0;
    logic [35:0] m_exp = '0, m_res = '0;
    logic [15:0] m_err = '0;
    logic [17:0] sr [35];                // emulated downstream column shift registers
    logic [35:0] fmask = '0;             // compressor output bits forced to 0
    bit          rdy_s = 1'b0;
    int          rv_cnt = 0, rv_last = 0, ones_cnt = 0;
    logic        last_mm = 1'b0;

    initial for (int k = 0; k < 35; k++) sr[k] = '0;

    // Which bit of the partial-product matrix each column line carries at sweep step t:
    // column k holds pp[i][j] with i+j=k, ordered by row i from the column base, sent highest first.
    function automatic logic [34:0] pp_lines(input int t, input logic [17:0] av, input logic [17:0] bv);
        logic [34:0] v = '0;
        for (int i = 0; i < 18; i++) begin
            for (int j = 0; j < 18; j++) begin
                int k    = i + j;
                int base = (k > 17) ? k - 17 : 0;
                if (17 - (i - base) == t) v[k] = av[i] & bv[j];
            end
        end
        return v;
    endfunction

    // Ideal compressor: weighted population count of every column register.
    function automatic logic [35:0] compress();
        logic [63:0] s = '0;
        for (int k = 0; k < 35; k++) s += 64'($countones(sr[k])) << k;
        return s[35:0];
    endfunction

    always @(negedge clk) begin
        rdy_s = rdy1;
        if (chk_en) begin
            check("in_ready", 64'(rdy1), 64'(ph == 0 && rst_n));
            check("src_lines", 64'(src1), (ph >= 1 && ph <= 18) ? 64'(pp_lines(ph - 1, m_a, m_b)) : 64'd0);
            check("result_valid", 64'(rv1), 64'(ph == 20));
            check("expected", 64'(exp1), 64'(m_exp));
            check("result", 64'(res1), 64'(m_res));
            check("err_count", 64'(err1), 64'(m_err));
            if (ph == 20) check("mismatch", 64'(mm1), 64'(m_res != m_exp));
        end
        if (rv1 === 1'b1) begin rv_cnt++; rv_last = cyc; last_mm = mm1; end
        ones_cnt += $countones(src1);
        // advance the model across the coming rising edge
        if (!rst_n) begin
            ph = 0; m_exp = '0; m_res = '0; m_err = '0;
        end else begin
            if (ph >= 1 && ph <= 18)
                for (int k = 0; k < 35; k++) sr[k] = {sr[k][16:0], src1[k]};
            if (ph == 19) m_res = dst1;
            if (ph == 20 && m_res != m_exp && m_err != 16'hFFFF) m_err++;
            if (ph == 0) begin
                if (iv1) begin m_a = a1; m_b = b1; m_exp = 36'(a1) * 36'(b1); ph = 1; end
            end else if (ph == 20) ph = 0;
            else ph++;
        end
        dst1 = compress() & ~fmask;
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [17:0] av, input logic [17:0] bv, output int acc);
        iv1 = 1'b1; a1 = av; b1 = bv; acc = -1;
        for (int i = 0; i < 100 && acc < 0; i++) begin
            @(posedge clk); #1;
            if (rdy_s) acc = cyc;
        end
        iv1 = 1'b0; a1 = 18'($urandom); b1 = 18'($urandom);
        if (acc < 0) begin checks++; errors++; $display("FAIL accept_timeout: got none, required accept"); end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk); #1;
            if (rdy1) ok = 1'b1;
        end
        if (!ok) begin checks++; errors++; $display("FAIL idle_timeout: got busy, required in_ready"); end
    endtask

    initial begin
        int acc, acc2, rv_before, rvc, rdc;
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        // all-ones operands: latency and full product
        send(18'h3FFFF, 18'h3FFFF, acc);
        wait_idle();
        check("lat_rv_cycle", 64'(rv_last - acc + 1), 64'd20);
        check("max_result", 64'(res1), 64'h0_FFFF_80001);
        check("max_expected", 64'(m_exp), 64'h0_FFFF_80001);
        check("max_mismatch", 64'(last_mm), 64'd0);

        // single partial product: exactly one line pulse in the whole sweep
        ones_cnt = 0;
        send(18'h00001, 18'h00001, acc);
        wait_idle();
        check("one_src_pulses", 64'(ones_cnt), 64'd1);
        check("one_result", 64'(res1), 64'h1);

        // back-to-back with in_valid kept high
        send(18'h12345, 18'h0F0F0, acc);
        send(18'h2ABCD, 18'h0F0F0, acc2);
        check("b2b_spacing", 64'(acc2 - acc), 64'd21);
        wait_idle();
        check("b2b_result", 64'(res1), 64'(36'h2ABCD * 36'h0F0F0));

        // stuck-at-0 on sum bit 5
        fmask = 36'd1 << 5;
        send(18'h00007, 18'h00007, acc);
        wait_idle();
        check("fault_mismatch", 64'(last_mm), 64'd1);
        check("fault_result", 64'(res1), 64'h11);
        check("fault_err_count", 64'(err1), 64'd1);
        fmask = '0;

        // randomized operands with occasional single-bit compressor faults
        for (int n = 0; n < 30; n++) begin
            fmask = ($urandom_range(0, 3) == 0) ? (36'd1 << $urandom_range(0, 35)) : 36'd0;
            send(18'($urandom), 18'($urandom), acc);
            wait_idle();
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        fmask = '0;
        repeat (2) @(posedge clk); #1;

        // reset during SHIFT at cnt=9, with in_valid offered during reset
        send(18'h00003, 18'h00005, acc);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0; iv1 = 1'b1;
        rv_before = rv_cnt;
        repeat (2) @(posedge clk);
        #1 iv1 = 1'b0; rst_n = 1'b1;
        repeat (25) @(posedge clk); #1;
        check("abort_no_rv", 64'(rv_cnt), 64'(rv_before));
        check("abort_err_cleared", 64'(err1), 64'd0);
        send(18'h00400, 18'h00200, acc);
        wait_idle();
        check("post_abort_result", 64'(res1), 64'h80000);
        check("post_abort_mismatch", 64'(last_mm), 64'd0);

        // SETTLE_CYCLES = 3 instance timing
        a3 = 18'h7; b3 = 18'h7; dst3 = 36'h31; iv3 = 1'b1;
        acc = -1;
        for (int i = 0; i < 50 && acc < 0; i++) begin
            @(negedge clk);
            if (rdy3) begin @(posedge clk); #1; acc = 1; end
        end
        iv3 = 1'b0;
        if (acc < 0) begin checks++; errors++; $display("FAIL s3_accept: got none, required accept"); end
        rvc = -1; rdc = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (rv3 && rvc < 0) begin rvc = c; check("s3_mismatch", 64'(mm3), 64'd0); end
            if (rdy3 && rdc < 0) rdc = c;
        end
        check("s3_rv_cycle", 64'(rvc), 64'd22);
        check("s3_ready_cycle", 64'(rdc), 64'd23);
        check("s3_result", 64'(res3), 64'h31);
        check("s3_expected", 64'(exp3), 64'h31);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

endmodule

`undef FEEDER_LINES
